// File: rtl/opfetch_pkg.sv
// Shared defaults and FSM encoding for the operand fetch stage.
// OPFETCH_FWD_EN (optional) enables writeback-to-read forwarding.
package opfetch_pkg;

   localparam int OF_DATA_W = 32;
   localparam int OF_REG_AW = 4;
   localparam int OF_OP_W   = 6;

   typedef enum logic {
      OF_EMPTY = 1'b0,
      OF_FULL  = 1'b1
   } of_state_e;

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write scoreboard: one bit per register, three lookups.
// A set and a clear of the same register in one cycle leaves it pending.
module opfetch_scoreboard
   import opfetch_pkg::*;
#(
   parameter int REG_AW = OF_REG_AW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_idx,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_idx,
   input  logic [REG_AW-1:0] q1_idx,
   input  logic [REG_AW-1:0] q2_idx,
   input  logic [REG_AW-1:0] q3_idx,
   output logic              q1_pend,
   output logic              q2_pend,
   output logic              q3_pend
);

   localparam int NREG = 1 << REG_AW;

   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_nxt;

   always_comb begin
      pend_nxt = pend;
      if (clr_en) pend_nxt[clr_idx] = 1'b0;
      if (set_en) pend_nxt[set_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pend <= '0;
      else          pend <= pend_nxt;
   end

   assign q1_pend = pend[q1_idx];
   assign q2_pend = pend[q2_idx];
   assign q3_pend = pend[q3_idx];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: bank read/write steering, hazard stall, output reg.
// Define OPFETCH_FWD_EN to forward same-cycle writeback data to reads.
module operand_fetch_stage
   import opfetch_pkg::*;
#(
   parameter int DATA_W = OF_DATA_W,
   parameter int REG_AW = OF_REG_AW,
   parameter int OP_W   = OF_OP_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [REG_AW-1:0] in_dst,
   input  logic [REG_AW-1:0] in_src1,
   input  logic [REG_AW-1:0] in_src2,
   output logic [REG_AW-1:0] bank_s1,
   output logic [REG_AW-1:0] bank_s2,
   input  logic [DATA_W-1:0] bank_out1,
   input  logic [DATA_W-1:0] bank_out2,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_dst,
   input  logic [DATA_W-1:0] wb_data,
   output logic              bank_we,
   output logic [REG_AW-1:0] bank_d,
   output logic [DATA_W-1:0] bank_ldr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OP_W-1:0]   out_op,
   output logic [REG_AW-1:0] out_dst,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b
);

   of_state_e         state;
   of_state_e         state_nxt;
   logic              p1, p2, p3;
   logic              h1, h2, h3;
   logic              hazard;
   logic              accept;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;

   assign bank_s1  = in_src1;
   assign bank_s2  = in_src2;
   assign bank_we  = wb_valid;
   assign bank_d   = wb_dst;
   assign bank_ldr = wb_data;

   opfetch_scoreboard #(.REG_AW(REG_AW)) u_sb (
      .clk     (clk),
      .reset_n (reset_n),
      .set_en  (accept),
      .set_idx (in_dst),
      .clr_en  (wb_valid),
      .clr_idx (wb_dst),
      .q1_idx  (in_src1),
      .q2_idx  (in_src2),
      .q3_idx  (in_dst),
      .q1_pend (p1),
      .q2_pend (p2),
      .q3_pend (p3)
   );

`ifdef OPFETCH_FWD_EN
   logic f1, f2, f3;

   assign f1  = wb_valid && (wb_dst == in_src1);
   assign f2  = wb_valid && (wb_dst == in_src2);
   assign f3  = wb_valid && (wb_dst == in_dst);
   assign h1  = p1 && !f1;
   assign h2  = p2 && !f2;
   assign h3  = p3 && !f3;
   // Bank writes land at the edge, so its read port still shows old data.
   assign opa = f1 ? wb_data : bank_out1;
   assign opb = f2 ? wb_data : bank_out2;
`else
   assign h1  = p1;
   assign h2  = p2;
   assign h3  = p3;
   assign opa = bank_out1;
   assign opb = bank_out2;
`endif

   assign hazard   = h1 | h2 | h3;
   assign in_ready = !hazard && ((state == OF_EMPTY) || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= OF_EMPTY;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         OF_EMPTY: if (accept)         state_nxt = OF_FULL;
         OF_FULL:  if (accept)         state_nxt = OF_FULL;
                   else if (out_ready) state_nxt = OF_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_op  <= '0;
         out_dst <= '0;
         out_a   <= '0;
         out_b   <= '0;
      end else if (accept) begin
         out_op  <= in_op;
         out_dst <= in_dst;
         out_a   <= opa;
         out_b   <= opb;
      end
   end

   assign out_valid = (state == OF_FULL);

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus random traffic
// against a register-bank and pending-set reference model.
`timescale 1ns/1ps
module tb_operand_fetch_stage;

`ifdef OPFETCH_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_op = '0;
   logic [3:0]  in_dst = '0;
   logic [3:0]  in_src1 = '0;
   logic [3:0]  in_src2 = '0;
   logic [3:0]  bank_s1, bank_s2;
   logic [31:0] bank_out1, bank_out2;
   logic        wb_valid = 1'b0;
   logic [3:0]  wb_dst = '0;
   logic [31:0] wb_data = '0;
   logic        bank_we;
   logic [3:0]  bank_d;
   logic [31:0] bank_ldr;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [5:0]  out_op;
   logic [3:0]  out_dst;
   logic [31:0] out_a, out_b;

   logic [31:0] bank [16];
   assign bank_out1 = bank[bank_s1];
   assign bank_out2 = bank[bank_s2];

   always #5 clk = ~clk;

   operand_fetch_stage dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
      .bank_s1(bank_s1), .bank_s2(bank_s2),
      .bank_out1(bank_out1), .bank_out2(bank_out2),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
      .bank_we(bank_we), .bank_d(bank_d), .bank_ldr(bank_ldr),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_dst(out_dst), .out_a(out_a), .out_b(out_b)
   );

   int nvec = 0;
   int nbad = 0;

   bit          mpend [16];
   bit          mv;
   logic [5:0]  mop;
   logic [3:0]  mdst;
   logic [31:0] ma, mb;
   logic [3:0]  infl [$];

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit blocked(logic [3:0] r);
      return mpend[r] && !(FWD && wb_valid && wb_dst == r);
   endfunction

   function automatic bit exp_ready();
      bit hz;
      hz = blocked(in_src1) || blocked(in_src2) || blocked(in_dst);
      return !hz && (!mv || out_ready);
   endfunction

   function automatic logic [31:0] exp_opnd(logic [3:0] r);
      if (FWD && wb_valid && wb_dst == r) return wb_data;
      return bank[r];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mpend[i] = 1'b0;
      mv = 1'b0; mop = '0; mdst = '0; ma = '0; mb = '0;
      infl.delete();
   endtask

   task automatic drive(bit v, logic [5:0] op, logic [3:0] d,
                        logic [3:0] s1, logic [3:0] s2, bit wv,
                        logic [3:0] wd, logic [31:0] wdat, bit ordy);
      in_valid = v; in_op = op; in_dst = d;
      in_src1 = s1; in_src2 = s2;
      wb_valid = wv; wb_dst = wd; wb_data = wdat;
      out_ready = ordy;
   endtask

   task automatic check_regs();
      check("out_valid", out_valid, mv);
      check("out_op", out_op, mop);
      check("out_dst", out_dst, mdst);
      check("out_a", out_a, ma);
      check("out_b", out_b, mb);
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic cycle();
      bit acc, fire;
      logic [31:0] ea, eb;
      #1;
      check("in_ready", in_ready, exp_ready());
      check("bank_s1", bank_s1, in_src1);
      check("bank_s2", bank_s2, in_src2);
      check("bank_we", bank_we, wb_valid);
      check("bank_d", bank_d, wb_dst);
      check("bank_ldr", bank_ldr, wb_data);
      acc  = in_valid && exp_ready();
      fire = mv && out_ready;
      ea   = exp_opnd(in_src1);
      eb   = exp_opnd(in_src2);
      @(posedge clk);
      #1;
      if (wb_valid) begin
         mpend[wb_dst] = 1'b0;
         bank[wb_dst]  = wb_data;
      end
      if (acc) begin
         mpend[in_dst] = 1'b1;
         infl.push_back(in_dst);
         mv = 1'b1; mop = in_op; mdst = in_dst; ma = ea; mb = eb;
      end else if (fire) begin
         mv = 1'b0;
      end
      check_regs();
      @(negedge clk);
   endtask

   task automatic idle_wb(logic [3:0] r);
      drive(0, 0, 0, 0, 0, 1, r, $urandom, 1);
      cycle();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) bank[i] = $urandom;
      model_reset();
      #1;
      check_regs();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // back-to-back
      bank[1] = 32'hAAAAAAAA;
      bank[2] = 32'hBBBBBBBB;
      drive(1, 6'h11, 5, 1, 2, 0, 0, 0, 1);
      cycle();
      check("b2b_a0", out_a, 32'hAAAAAAAA);
      check("b2b_b0", out_b, 32'hBBBBBBBB);
      drive(1, 6'h12, 6, 1, 2, 0, 0, 0, 1);
      cycle();
      check("b2b_v1", out_valid, 1);
      check("b2b_dst1", out_dst, 6);
      check("b2b_a1", out_a, 32'hAAAAAAAA);
      check("b2b_b1", out_b, 32'hBBBBBBBB);
      idle_wb(5);
      idle_wb(6);

      // RAW
      drive(1, 6'h21, 3, 0, 0, 0, 0, 0, 1);
      cycle();
      for (int i = 0; i < 2; i++) begin
         drive(1, 6'h22, 7, 3, 0, 0, 0, 0, 1);
         cycle();
      end
      drive(1, 6'h22, 7, 3, 0, 1, 3, 32'hCCCCCCCC, 1);
      cycle();
      if (!FWD) begin
         drive(1, 6'h22, 7, 3, 0, 0, 0, 0, 1);
         cycle();
      end
      check("raw_dst", out_dst, 7);
      check("raw_a", out_a, 32'hCCCCCCCC);
      idle_wb(7);

      // backpressure
      drive(1, 6'h31, 8, 1, 2, 0, 0, 0, 0);
      cycle();
      for (int i = 0; i < 4; i++) begin
         drive(1, 6'h32, 9, 0, 0, 0, 0, 0, 0);
         cycle();
         check("bp_dst", out_dst, 8);
         check("bp_a", out_a, 32'hAAAAAAAA);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle();
      check("bp_drain", out_valid, 0);
      idle_wb(8);

      // WAW, then same-cycle set and clear of r4
      drive(1, 6'h41, 4, 0, 0, 0, 0, 0, 1);
      cycle();
      drive(1, 6'h42, 4, 0, 0, 0, 0, 0, 1);
      cycle();
      drive(1, 6'h42, 4, 0, 0, 1, 4, 32'h44, 1);
      cycle();
      if (!FWD) begin
         drive(1, 6'h42, 4, 0, 0, 0, 0, 0, 1);
         cycle();
      end
      check("waw_dst", out_dst, 4);
      check("waw_op", out_op, 6'h42);
      idle_wb(4);
      drive(1, 6'h43, 4, 0, 0, 1, 4, 32'h55, 1);
      cycle();
      drive(1, 6'h44, 10, 4, 0, 0, 0, 0, 1);
      #1;
      check("setclr_pend4", in_ready, 0);
      cycle();
      idle_wb(4);

      // async reset while FULL with r3 pending
      drive(1, 6'h51, 3, 0, 0, 0, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("rst_valid", out_valid, 0);
      check_regs();
      @(negedge clk);
      reset_n = 1'b1;
      drive(1, 6'h52, 3, 3, 3, 0, 0, 0, 1);
      #1;
      check("rst_ready", in_ready, 1);
      cycle();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         bit wv;
         logic [3:0] wd;
         wv = 1'b0;
         wd = '0;
         if (infl.size() > 0 && $urandom_range(0, 1) == 1) begin
            int k;
            k  = $urandom_range(0, infl.size() - 1);
            wd = infl[k];
            infl.delete(k);
            wv = 1'b1;
         end else if ($urandom_range(0, 7) == 0) begin
            wd = 4'($urandom_range(0, 15));
            wv = 1'b1;
         end
         drive($urandom_range(0, 3) != 0, 6'($urandom),
               4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
               4'($urandom_range(0, 7)), wv, wd, $urandom,
               $urandom_range(0, 3) != 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
